// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC register, ROM addressing and IF/ID register with stall, redirect and fetch counter
module instruction_fetch #(
    parameter logic [9:0] RESET_PC = 10'd0,
    parameter int         CNT_W    = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iStall,
    input  logic             iBranchTaken,
    input  logic [9:0]       iBranchTarget,
    output logic [9:0]       oAddress,
    input  logic [15:0]      iInstruction,
    output logic [15:0]      oInstruction,
    output logic [9:0]       oPC,
    output logic             oValid,
    output logic [CNT_W-1:0] oFetchCount
);

    localparam logic [5:0]       NOP      = 6'b000000;
    localparam logic [15:0]      BUBBLE   = {NOP, 10'd0};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [9:0]       pc;
    logic [15:0]      ifid_instr;
    logic [9:0]       ifid_pc;
    logic             ifid_valid;
    logic [CNT_W-1:0] fetch_cnt;
    logic             cnt_full;

    // The ROM is combinational, so the PC register addresses it directly.
    assign oAddress     = pc;
    assign oInstruction = ifid_instr;
    assign oPC          = ifid_pc;
    assign oValid       = ifid_valid;
    assign oFetchCount  = fetch_cnt;
    assign cnt_full     = &fetch_cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc         <= RESET_PC;
            ifid_instr <= BUBBLE;
            ifid_pc    <= 10'd0;
            ifid_valid <= 1'b0;
            fetch_cnt  <= '0;
        end else if (iBranchTaken) begin
            // Redirect wins over stall; the instruction at the old PC is wrong-path.
            pc         <= iBranchTarget;
            ifid_instr <= BUBBLE;
            ifid_pc    <= 10'd0;
            ifid_valid <= 1'b0;
        end else if (!iStall) begin
            pc         <= pc + 10'd1;
            ifid_instr <= iInstruction;
            ifid_pc    <= pc;
            ifid_valid <= 1'b1;
            if (!cnt_full)
                fetch_cnt <= fetch_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed bench for instruction_fetch against a combinational ROM model
module tb_instruction_fetch;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iStall;
    logic        iBranchTaken;
    logic [9:0]  iBranchTarget;
    logic [9:0]  oAddress,  oAddress4;
    logic [15:0] iInstruction, iInstruction4;
    logic [15:0] oInstruction, oInstruction4;
    logic [9:0]  oPC, oPC4;
    logic        oValid, oValid4;
    logic [15:0] oFetchCount;
    logic [3:0]  oFetchCount4;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    function automatic logic [15:0] rom(input logic [9:0] a);
        return {a[5:0] ^ 6'h15, a};
    endfunction

    assign iInstruction  = rom(oAddress);
    assign iInstruction4 = rom(oAddress4);

    instruction_fetch #(.RESET_PC(10'd0), .CNT_W(16)) dut (
        .Clock(Clock), .Reset(Reset), .iStall(iStall), .iBranchTaken(iBranchTaken),
        .iBranchTarget(iBranchTarget), .oAddress(oAddress), .iInstruction(iInstruction),
        .oInstruction(oInstruction), .oPC(oPC), .oValid(oValid), .oFetchCount(oFetchCount)
    );

    instruction_fetch #(.RESET_PC(10'd0), .CNT_W(4)) dut4 (
        .Clock(Clock), .Reset(Reset), .iStall(iStall), .iBranchTaken(iBranchTaken),
        .iBranchTarget(iBranchTarget), .oAddress(oAddress4), .iInstruction(iInstruction4),
        .oInstruction(oInstruction4), .oPC(oPC4), .oValid(oValid4), .oFetchCount(oFetchCount4)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = 10'd0;
        tick();
        tick();
        total++; if (oAddress !== 10'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", oAddress); end
        total++; if (oInstruction !== 16'h0000) begin bad++; $display("FAIL reset_instr got=%h exp=0000", oInstruction); end
        total++; if (oPC !== 10'd0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", oPC); end
        total++; if (oValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", oValid); end
        total++; if (oFetchCount !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", oFetchCount); end
        Reset = 1'b0;
    endtask

    task automatic test_free_run();
        for (int k = 1; k <= 6; k++) begin
            tick();
            total++; if (oPC !== 10'(k-1)) begin bad++; $display("FAIL run_pc[%0d] got=%0d exp=%0d", k, oPC, k-1); end
            total++; if (oInstruction !== rom(10'(k-1))) begin bad++; $display("FAIL run_instr[%0d] got=%h exp=%h", k, oInstruction, rom(10'(k-1))); end
            total++; if (oValid !== 1'b1) begin bad++; $display("FAIL run_valid[%0d] got=%b exp=1", k, oValid); end
            total++; if (oAddress !== 10'(k)) begin bad++; $display("FAIL run_addr[%0d] got=%0d exp=%0d", k, oAddress, k); end
        end
        total++; if (oFetchCount !== 16'd6) begin bad++; $display("FAIL run_cnt got=%0d exp=6", oFetchCount); end
    endtask

    task automatic test_stall();
        tick();  // PC=7, IF/ID holds PC 6
        iStall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (oAddress !== 10'd7) begin bad++; $display("FAIL stall_addr[%0d] got=%0d exp=7", k, oAddress); end
            total++; if (oPC !== 10'd6 || oInstruction !== rom(10'd6)) begin bad++; $display("FAIL stall_ifid[%0d] got=%0d/%h exp=6/%h", k, oPC, oInstruction, rom(10'd6)); end
            total++; if (oFetchCount !== 16'd7) begin bad++; $display("FAIL stall_cnt[%0d] got=%0d exp=7", k, oFetchCount); end
        end
        iStall = 1'b0;
        tick();
        total++; if (oPC !== 10'd7 || oValid !== 1'b1) begin bad++; $display("FAIL stall_resume0 got=%0d/%b exp=7/1", oPC, oValid); end
        tick();
        total++; if (oPC !== 10'd8 || oInstruction !== rom(10'd8)) begin bad++; $display("FAIL stall_resume1 got=%0d/%h exp=8/%h", oPC, oInstruction, rom(10'd8)); end
        total++; if (oFetchCount !== 16'd9) begin bad++; $display("FAIL stall_resume_cnt got=%0d exp=9", oFetchCount); end
    endtask

    task automatic test_branch();
        tick(); tick();  // PC=11
        total++; if (oAddress !== 10'd11) begin bad++; $display("FAIL br_pre_addr got=%0d exp=11", oAddress); end
        iBranchTaken = 1'b1; iBranchTarget = 10'd19;
        tick();
        iBranchTaken = 1'b0; iBranchTarget = 10'd500;
        total++; if (oValid !== 1'b0 || oInstruction !== 16'h0000) begin bad++; $display("FAIL br_bubble got=%b/%h exp=0/0000", oValid, oInstruction); end
        total++; if (oAddress !== 10'd19) begin bad++; $display("FAIL br_addr got=%0d exp=19", oAddress); end
        total++; if (oFetchCount !== 16'd11) begin bad++; $display("FAIL br_cnt_bubble got=%0d exp=11", oFetchCount); end
        tick();
        total++; if (oPC !== 10'd19 || oInstruction !== rom(10'd19) || oValid !== 1'b1) begin bad++; $display("FAIL br_target got=%0d/%h/%b exp=19/%h/1", oPC, oInstruction, oValid, rom(10'd19)); end
        total++; if (oFetchCount !== 16'd12) begin bad++; $display("FAIL br_cnt got=%0d exp=12", oFetchCount); end
    endtask

    task automatic test_branch_over_stall();
        iBranchTaken = 1'b1; iStall = 1'b1; iBranchTarget = 10'd26;
        tick();
        iBranchTaken = 1'b0; iStall = 1'b0;
        total++; if (oAddress !== 10'd26 || oValid !== 1'b0) begin bad++; $display("FAIL brst got=%0d/%b exp=26/0", oAddress, oValid); end
        tick();
        total++; if (oPC !== 10'd26 || oFetchCount !== 16'd13) begin bad++; $display("FAIL brst_next got=%0d/%0d exp=26/13", oPC, oFetchCount); end
    endtask

    task automatic test_back_to_back();
        iBranchTaken = 1'b1; iBranchTarget = 10'd40;
        tick();
        total++; if (oAddress !== 10'd40 || oValid !== 1'b0) begin bad++; $display("FAIL b2b_0 got=%0d/%b exp=40/0", oAddress, oValid); end
        iBranchTarget = 10'd50;
        tick();
        total++; if (oAddress !== 10'd50 || oValid !== 1'b0) begin bad++; $display("FAIL b2b_1 got=%0d/%b exp=50/0", oAddress, oValid); end
        iBranchTaken = 1'b0;
        tick();
        total++; if (oPC !== 10'd50 || oFetchCount !== 16'd14) begin bad++; $display("FAIL b2b_2 got=%0d/%0d exp=50/14", oPC, oFetchCount); end
    endtask

    task automatic test_wrap();
        iBranchTaken = 1'b1; iBranchTarget = 10'd1022;
        tick();
        iBranchTaken = 1'b0;
        tick();
        total++; if (oPC !== 10'd1022 || oInstruction !== rom(10'd1022)) begin bad++; $display("FAIL wrap0 got=%0d exp=1022", oPC); end
        tick();
        total++; if (oPC !== 10'd1023) begin bad++; $display("FAIL wrap1 got=%0d exp=1023", oPC); end
        tick();
        total++; if (oPC !== 10'd0 || oInstruction !== rom(10'd0)) begin bad++; $display("FAIL wrap2 got=%0d/%h exp=0/%h", oPC, oInstruction, rom(10'd0)); end
        total++; if (oAddress !== 10'd1 || oFetchCount !== 16'd17) begin bad++; $display("FAIL wrap_state got=%0d/%0d exp=1/17", oAddress, oFetchCount); end
    endtask

    task automatic test_reset_override_and_saturate();
        iStall = 1'b1; iBranchTaken = 1'b1; iBranchTarget = 10'd5; Reset = 1'b1;
        tick();
        total++; if (oAddress !== 10'd0 || oValid !== 1'b0 || oPC !== 10'd0 || oInstruction !== 16'h0000) begin bad++; $display("FAIL rst_ovr got=%0d/%b/%0d/%h exp=0/0/0/0000", oAddress, oValid, oPC, oInstruction); end
        total++; if (oFetchCount !== 16'd0 || oFetchCount4 !== 4'd0) begin bad++; $display("FAIL rst_ovr_cnt got=%0d/%0d exp=0/0", oFetchCount, oFetchCount4); end
        Reset = 1'b0; iStall = 1'b0; iBranchTaken = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 15) begin
                total++; if (oFetchCount4 !== 4'd15) begin bad++; $display("FAIL sat_at15 got=%0d exp=15", oFetchCount4); end
            end
            if (k == 16) begin
                total++; if (oFetchCount4 !== 4'd15) begin bad++; $display("FAIL sat_at16 got=%0d exp=15", oFetchCount4); end
            end
        end
        total++; if (oFetchCount4 !== 4'd15) begin bad++; $display("FAIL sat_20 got=%0d exp=15", oFetchCount4); end
        total++; if (oFetchCount !== 16'd20) begin bad++; $display("FAIL cnt16_20 got=%0d exp=20", oFetchCount); end
        total++; if (oPC4 !== 10'd19 || oValid4 !== 1'b1) begin bad++; $display("FAIL dut4_pc got=%0d/%b exp=19/1", oPC4, oValid4); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_branch_over_stall();
        test_back_to_back();
        test_wrap();
        test_reset_override_and_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
